// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register-file geometry, architectural
// register indices and the common index/word types.
package mips_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 5;

   localparam int REG_ZERO = 0;
   localparam int REG_RA   = 31;

   typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;
   typedef logic [DEFAULT_DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational register-file read port: selects the addressed entry,
// forces $0 to zero and optionally forwards same-cycle write data.
module rf_read_port
   import mips_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int BYPASS = 1
) (
   input  logic [DATA_W-1:0] mem [2**ADDR_W],
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              bypass_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

   // Zero register beats everything, then forwarding, then the stored value.
   always_comb begin
      rd_data = mem[rd_addr];
      if (rd_addr == ZERO_IDX) begin
         rd_data = '0;
      end else if ((BYPASS != 0) && bypass_en && (wr_addr == rd_addr)) begin
         rd_data = wr_data;
      end
   end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 MIPS general-purpose register file: one write port from
// writeback, two ALU read ports with optional forwarding, one debug port.
module reg_file
   import mips_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int                DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              bypass_en;

   // Forwarding is only meaningful for a real write; in reset nothing is written
   // so nothing may be forwarded either.
   assign bypass_en = wr_en && rst_n && (wr_addr != ZERO_IDX);

   // Storage: async clear of every entry, writes to $0 are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && (wr_addr != ZERO_IDX)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_port_a (
      .mem       (mem),
      .rd_addr   (rd_addr1),
      .bypass_en (bypass_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data1)
   );

   rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_port_b (
      .mem       (mem),
      .rd_addr   (rd_addr2),
      .bypass_en (bypass_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data2)
   );

   // The debug port always shows architectural state, so forwarding is held off.
   rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_port_dbg (
      .mem       (mem),
      .rd_addr   (dbg_addr),
      .bypass_en (1'b0),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (dbg_data)
   );

endmodule

// File: tb/tb_reg_file.sv
// Randomised scoreboard bench for reg_file: a forwarding instance and a
// non-forwarding instance share stimulus and are checked against an array model.
module tb_reg_file;
   import mips_pkg::*;

   typedef struct {
      string name;
      word_t e1;
      word_t e2;
      word_t ed;
      word_t n1;
      word_t n2;
      word_t nd;
   } exp_t;

   logic     clk;
   logic     rst_n;
   reg_idx_t rd_addr1;
   reg_idx_t rd_addr2;
   logic     wr_en;
   reg_idx_t wr_addr;
   word_t    wr_data;
   reg_idx_t dbg_addr;

   word_t rd_data1, rd_data2, dbg_data;
   word_t nb_rd_data1, nb_rd_data2, nb_dbg_data;

   word_t    ref_mem [32];
   logic     pend_we;
   reg_idx_t pend_wa;
   word_t    pend_wd;

   exp_t exp_q [$];
   event strobe;

   int total_cnt = 0;
   int bad_cnt   = 0;

   reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_nb (
      .clk(clk), .rst_n(rst_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference read: reset forces 0, $0 is 0, forwarding only for a live write.
   function automatic word_t modelRead(input reg_idx_t idx, input bit byp);
      if (!rst_n) return '0;
      if (idx == 0) return '0;
      if (byp && wr_en && (wr_addr == idx)) return wr_data;
      return ref_mem[idx];
   endfunction

   task automatic pushExpect(input string name);
      exp_t e;
      e.name = name;
      e.e1 = modelRead(rd_addr1, 1'b1);
      e.e2 = modelRead(rd_addr2, 1'b1);
      e.ed = modelRead(dbg_addr, 1'b0);
      e.n1 = modelRead(rd_addr1, 1'b0);
      e.n2 = modelRead(rd_addr2, 1'b0);
      e.nd = modelRead(dbg_addr, 1'b0);
      exp_q.push_back(e);
   endtask

   task automatic commitPending();
      if (pend_we && rst_n && (pend_wa != 0)) ref_mem[pend_wa] = pend_wd;
   endtask

   // One cycle of stimulus: retire the write the DUT just latched, drive new inputs.
   task automatic applyStimulus(input logic we, input reg_idx_t wa, input word_t wd,
                                input reg_idx_t a1, input reg_idx_t a2,
                                input reg_idx_t ad, input string name);
      @(posedge clk);
      commitPending();
      #1;
      wr_en    = we;
      wr_addr  = wa;
      wr_data  = wd;
      rd_addr1 = a1;
      rd_addr2 = a2;
      dbg_addr = ad;
      pushExpect(name);
      pend_we = we;
      pend_wa = wa;
      pend_wd = wd;
   endtask

   // Assert reset in the middle of a cycle and sample straight away.
   task automatic resetPulse(input string name);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      pend_we = 1'b0;
      #1;
      pushExpect(name);
      ->strobe;
   endtask

   task automatic releaseReset();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic checkOutput(input string name, input string port,
                              input word_t act, input word_t exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("[TB] FAIL %s %s actual=%h required=%h", name, port, act, exp);
      end
   endtask

   // Monitor: every expectation is consumed by exactly one sample of the outputs.
   always begin : monitor
      exp_t e;
      @(negedge clk or strobe);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput(e.name, "rd_data1",    rd_data1,    e.e1);
         checkOutput(e.name, "rd_data2",    rd_data2,    e.e2);
         checkOutput(e.name, "dbg_data",    dbg_data,    e.ed);
         checkOutput(e.name, "nb_rd_data1", nb_rd_data1, e.n1);
         checkOutput(e.name, "nb_rd_data2", nb_rd_data2, e.n2);
         checkOutput(e.name, "nb_dbg_data", nb_dbg_data, e.nd);
      end
   end

   // Hard stop if the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reg_idx_t wa, a1, a2;
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr1 = '0;
      rd_addr2 = '0;
      dbg_addr = '0;
      pend_we  = 1'b0;
      pend_wa  = '0;
      pend_wd  = '0;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;

      // Reset state, with a write attempted while reset is held.
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd17, "reset_state");
      applyStimulus(1'b1, 5'd9, 32'h5555AAAA, 5'd9, 5'd9, 5'd9, "reset_write_ignored");
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd1, 5'd9, "reset_hold");
      releaseReset();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 5'd9, "after_release");

      // Reset clears a stored value asynchronously and it stays cleared.
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, "t1_write");
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 5'd5, "t1_stored");
      applyStimulus(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd5, 5'd5, "t1_write_again");
      resetPulse("t1_reset_async");
      applyStimulus(1'b1, 5'd5, 32'h11112222, 5'd5, 5'd5, 5'd5, "t1_reset_write");
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, "t1_reset_idle");
      releaseReset();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, "t1_after_release");

      // Zero register.
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, "t2_zero_write");
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, "t2_zero_read");

      // Write then read.
      applyStimulus(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0, 5'd7, "t3_write");
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 5'd7, "t3_read");

      // Same-cycle write and read of one register.
      applyStimulus(1'b1, 5'd3, 32'hA, 5'd0, 5'd0, 5'd3, "t4_seed");
      applyStimulus(1'b1, 5'd3, 32'hB, 5'd3, 5'd3, 5'd3, "t4_bypass");
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3, "t4_after");

      // Operands as the ALU would see them.
      applyStimulus(1'b1, 5'd1, 32'd5, 5'd0, 5'd0, 5'd0, "t5_w1");
      applyStimulus(1'b1, 5'd2, 32'd7, 5'd1, 5'd2, 5'd1, "t5_w2");
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd2, "t5_operands");

      // Inputs unknown while write enable is low.
      applyStimulus(1'b0, 'x, 'x, 5'd3, 5'd7, 5'd3, "x_inputs_idle");

      // Back-to-back sweep of every writable register, then read all back.
      for (int i = 1; i <= REG_RA; i++) begin
         applyStimulus(1'b1, reg_idx_t'(i), word_t'(i) * 32'h01010101,
                       reg_idx_t'(i - 1), reg_idx_t'(i), reg_idx_t'(i - 1), "t6_sweep_write");
      end
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 5'd0, 32'h0, reg_idx_t'(i), reg_idx_t'(31 - i),
                       reg_idx_t'(i), "t6_sweep_read");
      end

      // Random traffic with reads biased towards the register being written.
      for (int n = 0; n < 300; n++) begin
         wa = reg_idx_t'($urandom);
         a1 = ($urandom_range(2) == 0) ? wa : reg_idx_t'($urandom);
         a2 = ($urandom_range(2) == 0) ? wa : reg_idx_t'($urandom);
         applyStimulus(($urandom_range(9) < 7) ? 1'b1 : 1'b0, wa, word_t'($urandom),
                       a1, a2, ($urandom_range(1) == 0) ? wa : reg_idx_t'($urandom),
                       "random");
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, "final_idle");

      // Let the monitor drain; an expectation left behind is a failure.
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      total_cnt++;
      if (exp_q.size() > 0) begin
         bad_cnt++;
         $display("[TB] FAIL drain pending actual=%0d required=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
